imem_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the single-cycle CPU's instruction memory. It accepts a byte stream (length header, little-endian 16-bit instruction words, optional check byte) and writes each word into instruction memory at byte addresses 0, 2, 4, …, matching the CPU's PC+2 stepping. It holds the CPU in reset until the image is fully written, then releases it so the first fetch at address 0 sees the loaded program.

---
 rtl/loader_pkg.sv | 18 +
 rtl/loader_checksum.sv | 27 ++
 rtl/imem_loader.sv | 137 +++++++++++++
 tb/tb_imem_loader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: the FSM state
// encoding, the byte width and the default image-size limit.
package loader_pkg;

  localparam int BYTE_W            = 8;
  localparam int DEFAULT_MAX_WORDS = 256;

  typedef logic [2:0] state_t;

  localparam state_t S_LEN_LO  = 3'd0;
  localparam state_t S_LEN_HI  = 3'd1;
  localparam state_t S_DATA_LO = 3'd2;
  localparam state_t S_DATA_HI = 3'd3;
  localparam state_t S_CHK     = 3'd4;
  localparam state_t S_DONE    = 3'd5;
  localparam state_t S_ERR     = 3'd6;

endpackage

// File: rtl/loader_checksum.sv
// Running XOR over the accepted stream bytes. 'match' compares the byte
// currently on din against everything accumulated so far, so it is valid
// in the same cycle the check byte is presented.
module loader_checksum
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic [BYTE_W-1:0] din,
  output logic              match
);

  logic [BYTE_W-1:0] acc;

  // Accumulate each enabled byte; clr restarts the image.
  always_ff @(posedge clk) begin
    if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc ^ din;
    end
  end

  assign match = (din == acc);

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: parses a length-prefixed little-endian word stream and
// writes it to instruction memory at byte addresses 0, 2, 4, ... while
// holding the CPU in reset. Define LOADER_CHECKSUM_EN to build the trailing
// XOR check byte; without it the stream ends at the last word.
module imem_loader
  import loader_pkg::*;
#(
  parameter int MAX_WORDS = DEFAULT_MAX_WORDS,
  parameter int ADDR_W    = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [15:0]       im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] words_loaded
);

  state_t            state;
  logic [15:0]       len_q;
  logic [BYTE_W-1:0] wlo;
  logic              accept;
  logic [15:0]       n_hdr;
  logic              last_word;
  logic              chk_match;

  assign accept    = in_valid && in_ready;
  assign n_hdr     = {in_data, len_q[7:0]};
  // Word being written now is index words_loaded; it is the last one when
  // the count after this write reaches the header length.
  assign last_word = ({1'b0, len_q} == (17'(words_loaded) + 17'd1));

`ifdef LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;

  loader_checksum u_checksum (
    .clk   (CLK),
    .clr   (RESET),
    .en    (accept && (state != S_CHK)),
    .din   (in_data),
    .match (chk_match)
  );
`else
  localparam bit CHK_EN = 1'b0;
  assign chk_match = 1'b0;
`endif

  // Terminal states stop accepting; the CPU runs only a fully good image.
  assign in_ready = (state != S_DONE) && (state != S_ERR);
  assign cpu_hold = ~done;

  // Stream parser FSM with registered write port and status outputs.
  always_ff @(posedge CLK) begin
    // NOTE: reset is sampled on the clock edge here, so it must sit inside
    // the clocked block rather than in the sensitivity list.
    if (RESET) begin
      state        <= S_LEN_LO;
      len_q        <= '0;
      wlo          <= '0;
      im_we        <= 1'b0;
      im_addr      <= '0;
      im_wdata     <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update on this
      // edge based on the pre-edge values, independent of statement order.
      im_we <= 1'b0;
      if (accept) begin
        case (state)
          S_LEN_LO: begin
            len_q[7:0] <= in_data;
            state      <= S_LEN_HI;
          end
          S_LEN_HI: begin
            len_q <= n_hdr;
            if (n_hdr > 16'(MAX_WORDS)) begin
              state <= S_ERR;
              error <= 1'b1;
            end else if (n_hdr == 16'd0) begin
              if (CHK_EN) begin
                state <= S_CHK;
              end else begin
                state <= S_DONE;
                done  <= 1'b1;
              end
            end else begin
              state <= S_DATA_LO;
            end
          end
          S_DATA_LO: begin
            wlo   <= in_data;
            state <= S_DATA_HI;
          end
          S_DATA_HI: begin
            im_we        <= 1'b1;
            im_addr      <= {words_loaded[ADDR_W-2:0], 1'b0};
            im_wdata     <= {in_data, wlo};
            words_loaded <= words_loaded + ADDR_W'(1);
            if (last_word) begin
              if (CHK_EN) begin
                state <= S_CHK;
              end else begin
                state <= S_DONE;
                done  <= 1'b1;
              end
            end else begin
              state <= S_DATA_LO;
            end
          end
          S_CHK: begin
            if (chk_match) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
          S_DONE, S_ERR: ;
          default: begin
            state <= S_ERR;
            error <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed scoreboard bench for imem_loader. Expected writes are queued as
// stimulus is issued; a monitor pops and compares on every im_we pulse.
module tb_imem_loader;
  import loader_pkg::*;

  localparam int ADDR_W = 16;

`ifdef LOADER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RESET;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [15:0]       im_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [ADDR_W-1:0] words_loaded;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
    logic              done_now;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  imem_loader #(.MAX_WORDS(256), .ADDR_W(ADDR_W)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; the byte is taken at the next rising edge.
  task automatic send(input logic [7:0] b, input int gap);
    in_valid = 1'b0;
    repeat (gap) @(negedge CLK);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [15:0] d, input logic dn);
    wr_t w;
    w.addr = a; w.data = d; w.done_now = dn;
    exp_q.push_back(w);
  endtask

  task automatic do_reset();
    RESET    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
  endtask

  // Nominal two-word image; gap_max > 0 inserts random idle cycles.
  task automatic send_nominal(input int gap_max, input logic [7:0] chk_byte);
    logic [7:0] s [6];
    s = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
    expect_wr(16'h0000, 16'h1234, 1'b0);
    expect_wr(16'h0002, 16'h5678, !CHK);
    for (int i = 0; i < 6; i++)
      send(s[i], (gap_max > 0) ? $urandom_range(1, gap_max) : 0);
    if (CHK) send(chk_byte, (gap_max > 0) ? $urandom_range(1, gap_max) : 0);
  endtask

  // Monitor: every write must match the head of the scoreboard.
  initial begin
    wr_t w;
    forever begin
      @(negedge CLK);
      if (im_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0h data %0h, none expected", im_addr, im_wdata);
        end else begin
          w = exp_q.pop_front();
          check("wr_addr", 32'(im_addr), 32'(w.addr));
          check("wr_data", 32'(im_wdata), 32'(w.data));
          check("wr_done", 32'(done), 32'(w.done_now));
          check("wr_hold", 32'(cpu_hold), 32'(!w.done_now));
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check("rst_we",    32'(im_we),        32'd0);
    check("rst_done",  32'(done),         32'd0);
    check("rst_error", 32'(error),        32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    check("rst_addr",  32'(im_addr),      32'd0);
    check("rst_wdata", 32'(im_wdata),     32'd0);
    check("rst_hold",  32'(cpu_hold),     32'd1);
    check("rst_ready", 32'(in_ready),     32'd1);

    // Nominal load (also the no-check-byte case when the feature is off).
    send_nominal(0, 8'h0A);
    check("nom_done",  32'(done),         32'd1);
    check("nom_hold",  32'(cpu_hold),     32'd0);
    check("nom_words", 32'(words_loaded), 32'd2);
    check("nom_error", 32'(error),        32'd0);
    check("nom_ready", 32'(in_ready),     32'd0);

    // Wrong check byte: writes still happen, image rejected.
    do_reset();
    send_nominal(0, 8'h0B);
`ifdef LOADER_CHECKSUM_EN
    check("bad_error", 32'(error),    32'd1);
    check("bad_done",  32'(done),     32'd0);
    check("bad_hold",  32'(cpu_hold), 32'd1);
`else
    check("bad_done",  32'(done),     32'd1);
    check("bad_error", 32'(error),    32'd0);
`endif
    check("bad_ready", 32'(in_ready), 32'd0);

    // Oversize header: 257 words.
    do_reset();
    send(8'h01, 0);
    send(8'h01, 0);
    check("big_error", 32'(error),    32'd1);
    check("big_done",  32'(done),     32'd0);
    check("big_ready", 32'(in_ready), 32'd0);

    // Exactly MAX_WORDS is legal: header 00 01 must not error.
    do_reset();
    send(8'h00, 0);
    send(8'h01, 0);
    check("max_error", 32'(error),    32'd0);
    check("max_ready", 32'(in_ready), 32'd1);

    // Empty image.
    do_reset();
    send(8'h00, 0);
    send(8'h00, 0);
    if (CHK) send(8'h00, 0);
    check("empty_done",  32'(done),         32'd1);
    check("empty_words", 32'(words_loaded), 32'd0);
    check("empty_error", 32'(error),        32'd0);

    // Gaps between bytes, then bytes offered after done are refused.
    do_reset();
    send_nominal(5, 8'h0A);
    check("gap_done",  32'(done),         32'd1);
    check("gap_words", 32'(words_loaded), 32'd2);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    repeat (3) @(negedge CLK);
    in_valid = 1'b0;
    check("post_ready", 32'(in_ready),     32'd0);
    check("post_done",  32'(done),         32'd1);
    check("post_words", 32'(words_loaded), 32'd2);

    // Reset in the middle of an image, then a fresh one-word image.
    do_reset();
    send(8'h02, 0);
    send(8'h00, 0);
    send(8'h34, 0);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("mid_state", 32'(dut.state),     32'(S_LEN_LO));
    check("mid_we",    32'(im_we),         32'd0);
    check("mid_words", 32'(words_loaded),  32'd0);
    check("mid_hold",  32'(cpu_hold),      32'd1);
    expect_wr(16'h0000, 16'hABCD, !CHK);
    send(8'h01, 0);
    send(8'h00, 0);
    send(8'hCD, 0);
    send(8'hAB, 0);
    send(8'h67, 0);
    check("mid2_done",  32'(done),         32'd1);
    check("mid2_words", 32'(words_loaded), 32'd1);

    repeat (3) @(negedge CLK);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
